// File: rtl/mfcc_pkg.sv
// Shared constants for the MFCC front end: I2S/PCM defaults and derived counter widths.
package mfcc_pkg;

  localparam int unsigned PCM_SAMPLE_WIDTH = 16;
  localparam int unsigned I2S_SLOT_BITS    = 32;
  localparam int unsigned I2S_BCLK_DIV     = 32;

  localparam int unsigned I2S_DIV_CNT_W = $clog2(I2S_BCLK_DIV);
  localparam int unsigned I2S_BIT_CNT_W = $clog2(2 * I2S_SLOT_BITS);

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } i2s_slot_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_pcm_rx_if.sv
// Pin bundle between the I2S microphone receiver and its host/consumer.
interface i2s_pcm_rx_if
  import mfcc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = PCM_SAMPLE_WIDTH
) ();

  logic                    enable_i;
  logic                    sd_i;
  logic                    bclk_o;
  logic                    lrclk_o;
  logic [SAMPLE_WIDTH-1:0] pcm_o;
  logic                    pcm_ready_o;

  modport master (
    input  enable_i,
    input  sd_i,
    output bclk_o,
    output lrclk_o,
    output pcm_o,
    output pcm_ready_o
  );

  modport slave (
    output enable_i,
    output sd_i,
    input  bclk_o,
    input  lrclk_o,
    input  pcm_o,
    input  pcm_ready_o
  );

endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK divider: registered bit clock plus single-cycle rise/fall event flags
// asserted on the terminal-count cycle just before bclk_o toggles.
module i2s_clk_gen
  import mfcc_pkg::*;
#(
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = cnt_width(BCLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bclk;
  logic             w_tc;

  assign w_tc   = enable_i && (r_cnt == CNT_W'(BCLK_DIV - 1));
  assign rise_o = w_tc && !r_bclk;
  assign fall_o = w_tc &&  r_bclk;
  assign bclk_o = r_bclk;

  // Counter parks at zero while idle so every enable starts a clean half-period.
  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
      if (w_tc) begin
        r_bclk <= ~r_bclk;
      end
    end
  end

endmodule

// File: rtl/i2s_pcm_rx.sv
// I2S master receiver: generates BCLK/LRCLK, captures one channel MSB-first
// with the I2S one-bit delay and emits one PCM sample strobe per frame.
module i2s_pcm_rx
  import mfcc_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = PCM_SAMPLE_WIDTH,
  parameter int unsigned SLOT_BITS    = I2S_SLOT_BITS,
  parameter int unsigned BCLK_DIV     = I2S_BCLK_DIV,
  parameter int unsigned CHANNEL      = 0
) (
  input  logic          clk,
  input  logic          rst,
  i2s_pcm_rx_if.master  bus
);

  localparam int unsigned BIT_W    = cnt_width(2 * SLOT_BITS);
  localparam i2s_slot_e   SEL_SLOT = (CHANNEL != 0) ? SLOT_RIGHT : SLOT_LEFT;

  logic                    w_bclk;
  logic                    w_rise;
  logic                    w_fall;
  logic                    r_sync1;
  logic                    r_sync2;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [BIT_W-1:0]        w_bit_nxt;
  logic [BIT_W-1:0]        w_pos;
  i2s_slot_e               w_slot;
  logic                    w_cap;
  logic                    w_last;
  logic                    r_lrclk;
  logic [SAMPLE_WIDTH-1:0] r_shift;
  logic [SAMPLE_WIDTH-1:0] w_shift_nxt;
  logic [SAMPLE_WIDTH-1:0] r_pcm;
  logic                    r_ready;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .enable_i (bus.enable_i),
    .bclk_o   (w_bclk),
    .rise_o   (w_rise),
    .fall_o   (w_fall)
  );

  assign w_bit_nxt = (r_bit_cnt == BIT_W'(2 * SLOT_BITS - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
  assign w_slot    = (r_bit_cnt >= BIT_W'(SLOT_BITS)) ? SLOT_RIGHT : SLOT_LEFT;
  assign w_pos     = (w_slot == SLOT_RIGHT) ? r_bit_cnt - BIT_W'(SLOT_BITS) : r_bit_cnt;

  // Position 0 carries the previous word's LSB (one-bit delay); bits past the
  // sample width are the truncated tail of a longer microphone word.
  assign w_cap  = w_rise && (w_slot == SEL_SLOT) && (w_pos != '0)
                  && (w_pos <= BIT_W'(SAMPLE_WIDTH));
  assign w_last = w_rise && (w_slot == SEL_SLOT) && (w_pos == BIT_W'(SAMPLE_WIDTH));

  assign w_shift_nxt = {r_shift[SAMPLE_WIDTH-2:0], r_sync2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_bit_cnt <= '0;
      r_lrclk   <= 1'b0;
      r_shift   <= '0;
      r_pcm     <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_sync1 <= bus.sd_i;
      r_sync2 <= r_sync1;
      // Disable discards any partial word but keeps the last delivered sample.
      if (!bus.enable_i) begin
        r_bit_cnt <= '0;
        r_lrclk   <= 1'b0;
        r_shift   <= '0;
        r_ready   <= 1'b0;
      end else begin
        r_ready <= w_last;
        if (w_fall) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrclk   <= (w_bit_nxt >= BIT_W'(SLOT_BITS));
        end
        if (w_cap) begin
          r_shift <= w_shift_nxt;
        end
        if (w_last) begin
          r_pcm <= w_shift_nxt;
        end
      end
    end
  end

  assign bus.bclk_o      = w_bclk;
  assign bus.lrclk_o     = r_lrclk;
  assign bus.pcm_o       = r_pcm;
  assign bus.pcm_ready_o = r_ready;

endmodule

// File: tb/tb_i2s_pcm_rx.sv
// Bench for i2s_pcm_rx: left and right receivers share one microphone model;
// words are queued as the mic sends them and compared at each strobe.
module tb_i2s_pcm_rx;
  import mfcc_pkg::*;

  localparam int unsigned SW   = 16;
  localparam int unsigned SLOT = 32;
  localparam int unsigned DIV  = 4;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic sd     = 1'b0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  i2s_pcm_rx_if #(.SAMPLE_WIDTH(SW)) bus_l ();
  i2s_pcm_rx_if #(.SAMPLE_WIDTH(SW)) bus_r ();

  assign bus_l.enable_i = enable;
  assign bus_l.sd_i     = sd;
  assign bus_r.enable_i = enable;
  assign bus_r.sd_i     = sd;

  i2s_pcm_rx #(
    .SAMPLE_WIDTH (SW), .SLOT_BITS (SLOT), .BCLK_DIV (DIV), .CHANNEL (0)
  ) u_dut_l (
    .clk (clk), .rst (rst), .bus (bus_l.master)
  );

  i2s_pcm_rx #(
    .SAMPLE_WIDTH (SW), .SLOT_BITS (SLOT), .BCLK_DIV (DIV), .CHANNEL (1)
  ) u_dut_r (
    .clk (clk), .rst (rst), .bus (bus_r.master)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Microphone model: new bit after each BCLK fall, MSB one bit after LRCLK changes.
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];
  logic [23:0] ext_q[$];
  logic [23:0] word_l    = '0;
  logic [23:0] word_r    = '0;
  logic [23:0] nxt;
  logic        mic_lr    = 1'b0;
  logic        bclk_prev = 1'b0;
  logic        pend      = 1'b0;
  logic        pend_bit  = 1'b0;
  logic        b;
  int          mic_idx   = 0;
  bit          rand_mode = 1'b0;
  bit          late      = 1'b0;

  always @(negedge clk) begin
    if (rst || !enable) begin
      mic_lr    = 1'b0;
      mic_idx   = 0;
      pend      = 1'b0;
      sd        = 1'b0;
      q_l.delete();
      q_r.delete();
      bclk_prev = bus_l.bclk_o;
    end else begin
      if (pend) begin
        sd   = pend_bit;
        pend = 1'b0;
      end
      if (bclk_prev && !bus_l.bclk_o) begin
        if (bus_l.lrclk_o != mic_lr) mic_idx = 0;
        else                         mic_idx++;
        mic_lr = bus_l.lrclk_o;
        if (mic_idx == 1) begin
          if (!mic_lr) begin
            if (ext_q.size() > 0) nxt = ext_q.pop_front();
            else if (rand_mode)   nxt = 24'($urandom());
            else                  nxt = 24'hA5C3E1;
            word_l = nxt;
            q_l.push_back(nxt[23:8]);
          end else begin
            nxt    = rand_mode ? 24'($urandom()) : 24'h123456;
            word_r = nxt;
            q_r.push_back(nxt[23:8]);
          end
        end
        if (mic_idx >= 1 && mic_idx <= 24)
          b = mic_lr ? word_r[24-mic_idx] : word_l[24-mic_idx];
        else
          b = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        if (late) begin
          pend_bit = b;
          pend     = 1'b1;
        end else begin
          sd = b;
        end
      end
      bclk_prev = bus_l.bclk_o;
    end
  end

  // Strobe monitor: every strobe must match the oldest word sent in its slot.
  int          strb_l = 0;
  int          strb_r = 0;
  logic [15:0] last_l = '0;
  logic [15:0] exp_v;

  always @(negedge clk) begin
    if (bus_l.pcm_ready_o) begin
      strb_l++;
      if (q_l.size() == 0) begin
        chk("strobe_l_unexpected", 32'(q_l.size()), 32'd1);
      end else begin
        exp_v  = q_l.pop_front();
        last_l = exp_v;
        chk("pcm_l", 32'(bus_l.pcm_o), 32'(exp_v));
      end
    end
    if (bus_r.pcm_ready_o) begin
      strb_r++;
      if (q_r.size() == 0) begin
        chk("strobe_r_unexpected", 32'(q_r.size()), 32'd1);
      end else begin
        exp_v = q_r.pop_front();
        chk("pcm_r", 32'(bus_r.pcm_o), 32'(exp_v));
      end
    end
  end

  task automatic first_ready(input int max_cyc, output int first_l, output int first_r);
    first_l = 0;
    first_r = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_l.pcm_ready_o && first_l == 0) first_l = n;
      if (bus_r.pcm_ready_o && first_r == 0) first_r = n;
    end
  endtask

  initial begin
    int   bclk_r1, bclk_r2, lr_rise, lr_fall, rdy_l1, rdy_l_cnt, rdy_r1;
    int   fl, fr;
    logic pb, pl;
    bit   found;

    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    // Reset held with enable high: everything stays quiet.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out_l", 32'({bus_l.bclk_o, bus_l.lrclk_o, bus_l.pcm_o, bus_l.pcm_ready_o}), 32'd0);
      chk("rst_out_r", 32'({bus_r.bclk_o, bus_r.lrclk_o, bus_r.pcm_o, bus_r.pcm_ready_o}), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    bclk_r1 = 0; bclk_r2 = 0; lr_rise = 0; lr_fall = 0;
    rdy_l1 = 0; rdy_l_cnt = 0; rdy_r1 = 0; pb = 1'b0; pl = 1'b0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_l.bclk_o && !pb) begin
        if (bclk_r1 == 0)      bclk_r1 = n;
        else if (bclk_r2 == 0) bclk_r2 = n;
      end
      if (bus_l.lrclk_o && !pl && lr_rise == 0) lr_rise = n;
      if (!bus_l.lrclk_o && pl && lr_fall == 0) lr_fall = n;
      if (bus_l.pcm_ready_o) begin
        rdy_l_cnt++;
        if (rdy_l1 == 0) rdy_l1 = n;
      end
      if (bus_r.pcm_ready_o && rdy_r1 == 0) rdy_r1 = n;
      pb = bus_l.bclk_o;
      pl = bus_l.lrclk_o;
    end
    chk("bclk_first_rise", 32'(bclk_r1), 32'd4);
    chk("bclk_period", 32'(bclk_r2 - bclk_r1), 32'd8);
    chk("lrclk_rise", 32'(lr_rise), 32'd256);
    chk("lrclk_high_len", 32'(lr_fall - lr_rise), 32'd256);
    chk("first_ready_l", 32'(rdy_l1), 32'd132);
    chk("ready_cnt_l", 32'(rdy_l_cnt), 32'd2);
    chk("first_ready_r", 32'(rdy_r1), 32'd388);

    // Fixed pattern, six frames: one strobe per frame on each channel.
    @(posedge clk);
    #1 strb_l = 0; strb_r = 0;
    repeat (6 * 512) @(posedge clk);
    #1;
    chk("frames_l", 32'(strb_l), 32'd6);
    chk("frames_r", 32'(strb_r), 32'd6);

    // Full-scale words on the left channel.
    ext_q.push_back(24'h800000);
    ext_q.push_back(24'h7FFFFF);
    ext_q.push_back(24'hFFFFFF);
    strb_l = 0;
    repeat (4 * 512) @(posedge clk);
    #1;
    chk("ext_frames_l", 32'(strb_l), 32'd4);
    chk("ext_last_l", 32'(last_l), 32'h0000A5C3);

    // Abort inside left-slot bit 8, idle 20 cycles, then restart.
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (!mic_lr && mic_idx == 8) found = 1'b1;
    end
    chk("abort_point_found", 32'(found), 32'd1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_bclk", 32'(bus_l.bclk_o), 32'd0);
    chk("abort_lrclk", 32'(bus_l.lrclk_o), 32'd0);
    chk("abort_pcm_hold", 32'(bus_l.pcm_o), 32'(last_l));
    repeat (19) @(posedge clk);
    #1 enable = 1'b1;
    first_ready(400, fl, fr);
    chk("reenable_ready_l", 32'(fl), 32'd132);
    chk("reenable_ready_r", 32'(fr), 32'd388);

    // Random words and don't-care bits, data moved one clk after each BCLK fall.
    rand_mode = 1'b1;
    late      = 1'b1;
    @(posedge clk);
    #1 strb_l = 0; strb_r = 0;
    repeat (40 * 512) @(posedge clk);
    #1;
    chk("rand_frames_l", 32'(strb_l), 32'd40);
    chk("rand_frames_r", 32'(strb_r), 32'd40);

    // Mid-frame reset with enable held high.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_pcm_l", 32'(bus_l.pcm_o), 32'd0);
    chk("midrst_pcm_r", 32'(bus_r.pcm_o), 32'd0);
    chk("midrst_bclk", 32'(bus_l.bclk_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    first_ready(140, fl, fr);
    chk("post_rst_ready_l", 32'(fl), 32'd132);

    @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
